// File: rtl/mult_sequencer_if.sv
// Operand and result valid/ready channels between a client and the multiplier sequencer.
interface mult_sequencer_if #(parameter int WIDTH = 32);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic               out_timeout;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_timeout
  );
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_timeout
  );
endinterface

// File: rtl/mult_sequencer.sv
// Valid/ready wrapper around a start/done sequential multiplier, with a watchdog on done.
module mult_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 80
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_sequencer_if.slave    bus,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  input  logic [2*WIDTH-1:0] mul_result,
  input  logic               mul_done,
  output logic               busy
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt;
  logic               res_vld, res_to;
  logic [2*WIDTH-1:0] res_q;
  logic               accept, expired;

  assign bus.in_ready    = (state == IDLE) | ((state == HOLD) & bus.out_ready);
  assign accept          = bus.in_valid & bus.in_ready;
  assign expired         = (cnt == CNT_LAST);
  assign bus.out_valid   = res_vld;
  assign bus.out_result  = res_q;
  assign bus.out_timeout = res_to;
  assign mul_a           = a_q;
  assign mul_b           = b_q;
  assign mul_start       = (state == ISSUE);
  assign busy            = (state == ISSUE) | (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (mul_done || expired) state_nxt = HOLD;
      HOLD:  if (bus.out_ready) state_nxt = bus.in_valid ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      res_vld <= 1'b0;
      res_to  <= 1'b0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      // done takes priority over a watchdog expiry in the same cycle
      if (state == WAIT) begin
        if (mul_done) begin
          res_q   <= mul_result;
          res_to  <= 1'b0;
          res_vld <= 1'b1;
        end else if (expired) begin
          res_q   <= '0;
          res_to  <= 1'b1;
          res_vld <= 1'b1;
        end
      end else if (state == HOLD && bus.out_ready) begin
        res_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mult_sequencer.sv
// Randomized and directed checks of mult_sequencer against a transaction-level model.
module tb_mult_sequencer;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 80;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_start, mul_done, busy;
  logic [2*WIDTH-1:0] mul_result;

  mult_sequencer_if #(.WIDTH(WIDTH)) bus();

  mult_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_result(mul_result), .mul_done(mul_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // multiplier stub: done 'lat' cycles after start; lat 0 means it never finishes
  logic        rand_mode = 1'b0;
  int          stub_lat = 1;
  int          scnt = 0;
  logic        stub_done = 1'b0;
  logic        inj_done = 1'b0;
  logic [63:0] stub_res = '0;
  logic [31:0] sa = '0, sb = '0;

  assign mul_done   = stub_done | inj_done;
  assign mul_result = stub_res;

  always @(posedge clk) begin
    #1;
    stub_done = 1'b0;
    if (mul_start) begin
      sa = mul_a;
      sb = mul_b;
      if (rand_mode) scnt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      else           scnt = stub_lat;
    end else if (scnt > 0) begin
      scnt--;
      if (scnt == 0) begin
        stub_done = 1'b1;
        stub_res  = 64'(sa) * 64'(sb);
      end
    end
  end

  // transaction-level model: in flight / start owed / result presented
  logic        m_pend = 0, m_start_due = 0, m_rv = 0, m_rto = 0;
  logic [63:0] m_res = '0;
  logic [31:0] m_a = '0, m_b = '0;
  int          m_wait = 0;
  int          ret_total = 0;
  logic [64:0] ret_q[$];

  always @(negedge clk) begin
    logic exp_ready;
    if (!rst_n) begin
      m_pend = 0; m_start_due = 0; m_rv = 0; m_rto = 0; m_res = '0;
      m_a = '0; m_b = '0; m_wait = 0;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mul_start", 64'(mul_start), 64'd0);
      chk("rst_out_result", bus.out_result, 64'd0);
    end else begin
      exp_ready = !m_pend && (!m_rv || bus.out_ready);
      chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(m_pend));
      chk("mul_start", 64'(mul_start), 64'(m_start_due));
      chk("mul_a", 64'(mul_a), 64'(m_a));
      chk("mul_b", 64'(mul_b), 64'(m_b));
      chk("out_valid", 64'(bus.out_valid), 64'(m_rv));
      if (m_rv) begin
        chk("out_result", bus.out_result, m_res);
        chk("out_timeout", 64'(bus.out_timeout), 64'(m_rto));
      end
      if (m_rv && bus.out_ready) begin
        ret_q.push_back({m_rto, m_res});
        ret_total++;
        m_rv = 0;
      end
      if (m_pend && !m_start_due) begin
        if (mul_done) begin
          m_rv = 1; m_rto = 0; m_res = 64'(m_a) * 64'(m_b); m_pend = 0;
        end else if (m_wait == TIMEOUT - 1) begin
          m_rv = 1; m_rto = 1; m_res = '0; m_pend = 0;
        end else begin
          m_wait++;
        end
      end
      if (m_start_due) begin
        m_start_due = 0;
        m_wait = 0;
      end
      if (bus.in_valid && exp_ready) begin
        m_pend = 1; m_start_due = 1; m_a = bus.in_a; m_b = bus.in_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_ret(input string nm, input logic [63:0] res, input logic to);
    logic [64:0] e;
    int n = 0;
    while (ret_q.size() == 0 && n < 300) begin
      tick();
      n++;
    end
    if (ret_q.size() == 0) begin
      chk({nm, "_wait_expired"}, 64'd1, 64'd0);
    end else begin
      e = ret_q.pop_front();
      chk({nm, "_result"}, e[63:0], res);
      chk({nm, "_timeout"}, 64'(e[64]), 64'(to));
    end
  endtask

  initial begin
    int n;
    int target;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    tick();

    // basic 3x5
    stub_lat = 33;
    send(32'd3, 32'd5);
    chk("basic_start", 64'(mul_start), 64'd1);
    chk("basic_ready_busy", 64'(bus.in_ready), 64'd0);
    expect_ret("basic", 64'd15, 1'b0);

    // maximum operands
    stub_lat = 12;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_ret("max", 64'hFFFF_FFFE_0000_0001, 1'b0);

    // backpressure, then back-to-back acceptance on the retiring cycle
    stub_lat = 5;
    bus.out_ready = 1'b0;
    send(32'd7, 32'd9);
    n = 0;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    repeat (10) tick();
    chk("bp_held_result", bus.out_result, 64'd63);
    chk("bp_held_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    send(32'd2, 32'd4);
    chk("b2b_start", 64'(mul_start), 64'd1);
    expect_ret("bp", 64'd63, 1'b0);
    expect_ret("b2b", 64'd8, 1'b0);

    // watchdog, then a late done that must be ignored
    stub_lat = 0;
    send(32'd10, 32'd10);
    expect_ret("timeout", 64'd0, 1'b1);
    repeat (4) tick();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (5) tick();
    chk("late_done_no_ret", 64'(ret_q.size()), 64'd0);
    chk("late_done_no_valid", 64'(bus.out_valid), 64'd0);

    // reset mid-WAIT, stale done in IDLE, then a fresh transaction
    stub_lat = 50;
    send(32'd4, 32'd4);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_in_ready", 64'(bus.in_ready), 64'd1);
    chk("async_mul_a", 64'(mul_a), 64'd0);
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    chk("stale_done_no_ret", 64'(ret_q.size()), 64'd0);
    stub_lat = 3;
    send(32'd6, 32'd7);
    expect_ret("after_reset", 64'd42, 1'b0);

    // randomized traffic, model checks every cycle
    rand_mode = 1'b1;
    target = ret_total + 40;
    n = 0;
    while (ret_total < target && n < 20000) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in_a      = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.in_b      = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk("random_progress", 64'(ret_total >= target), 64'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((busy || bus.out_valid) && n < 300) begin tick(); n++; end
    chk("random_drain", 64'(busy || bus.out_valid), 64'd0);
    rand_mode = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Handshake front/back end for the sequential multiplier. It accepts operand pairs on a valid/ready input channel, drives the multiplier's a/b/start pins, and waits for its one-cycle done pulse. It then registers the 64-bit product and presents it on a valid/ready output channel. A watchdog flags a multiplier that never signals done.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH
TIMEOUT, 80, max cycles in WAIT before a timeout result is forced (must be >= 2)

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept operands this cycle
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  2*WIDTH  product (0 on timeout)
out_timeout  output  1  qualifies out_result: 1 = multiplier never finished
mul_a  output  WIDTH  to multiplier a
mul_b  output  WIDTH  to multiplier b
mul_start  output  1  to multiplier start, one-cycle pulse
mul_result  input  2*WIDTH  from multiplier result
mul_done  input  1  from multiplier done
busy  output  1  high in ISSUE or WAIT

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values: state IDLE; out_valid, out_timeout, mul_start, busy = 0; out_result, mul_a, mul_b, operand registers, watchdog counter = 0.
- States: IDLE, ISSUE, WAIT, HOLD (registered, one-hot or binary as implementer chooses).
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational and never depends on in_valid.
- IDLE: on in_valid & in_ready, latch in_a/in_b into the operand registers and go to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle. Clear the watchdog counter and go to WAIT.
- mul_a/mul_b are driven from the operand registers. They are stable from the ISSUE cycle until the next operand acceptance, and never change while busy.
- WAIT: the counter increments each cycle.
  - mul_done=1: out_result<=mul_result, out_timeout<=0, out_valid<=1, go to HOLD.
  - Else if counter==TIMEOUT-1: out_result<=0, out_timeout<=1, out_valid<=1, go to HOLD.
  - mul_done on the same cycle as the timeout: done wins, normal result.
- HOLD: out_valid, out_result and out_timeout are held stable until out_ready.
  - On out_ready with no new acceptance: out_valid<=0, go to IDLE.
  - On out_ready with in_valid (back-to-back): the result retires, new operands are latched, and the FSM goes directly to ISSUE.
- Latency: operands accepted at edge T gives mul_start high during cycle T+1. mul_done sampled at edge D gives out_valid high from D+1.
- mul_done outside WAIT (spurious, or late after timeout/reset) is ignored with no state change.
- Timeout does not reset the multiplier. A stale done arriving later is ignored per the rule above.
- Reset mid-operation aborts immediately; any in-flight result is discarded.
- Product width: out_result is the full 2*WIDTH, with no truncation or sign handling (unsigned).
- Exactly one mul_start per accepted operand pair; no start is issued without an acceptance.

Test Plan:
- Basic: in_a=3, in_b=5 accepted, multiplier model done after 33 cycles with result 15 -> exactly one mul_start, out_valid with out_result=15, out_timeout=0; in_ready=0 while busy.
- Max operands: 0xFFFFFFFF x 0xFFFFFFFF -> out_result=0xFFFFFFFE00000001; mul_a/mul_b stable through WAIT.
- Backpressure and back-to-back:
  - Setup: result 7x9=63 with out_ready=0 for 10 cycles -> out_valid/out_result held at 63, in_ready=0.
  - Then out_ready=1 with in_valid (2x4) the same cycle -> 63 retired, next mul_start on the following cycle, next result 8.
- Timeout: multiplier stub never asserts done -> out_valid after TIMEOUT cycles in WAIT with out_result=0, out_timeout=1. A stub done arriving 5 cycles later is ignored and the FSM stays in HOLD/IDLE.
- Reset and spurious done:
  - Setup: rst_n low 2 cycles midway through WAIT.
  - Required: all outputs reset immediately, asynchronous to clk.
  - A subsequent mul_done in IDLE produces no out_valid.
  - The next transaction (6x7) completes with 42.
